// File: rtl/gradient_pkg.sv
// Shared types and constants for the Lucas-Kanade gradient stage.
package gradient_pkg;

   localparam int X_WIDTH        = 10;
   localparam int Y_WIDTH        = 9;
   localparam int GRAD_WIDTH_DEF = 9;

   typedef enum logic {
      IDLE,
      STREAM
   } state_e;

   // Default-width gradient triple for downstream consumers; the calculator
   // declares its own copy sized by its GRAD_WIDTH parameter.
   typedef struct packed {
      logic signed [GRAD_WIDTH_DEF-1:0] gx;
      logic signed [GRAD_WIDTH_DEF-1:0] gy;
      logic signed [GRAD_WIDTH_DEF-1:0] gt;
   } grad_t_s;

endpackage

// File: rtl/gradient_calc_line_buffer.sv
// Valid-enabled circular delay line: dout presents the sample written DEPTH+1
// enables earlier, via a RAM with registered read-before-write.
module line_buffer
   import gradient_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 319
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] dout_reg;
   logic [AW-1:0]    ptr_reg;

   // The output register is the final stage of the delay, so DEPTH+1 enables total.
   always_ff @(posedge clk) begin
      if (en) begin
         dout_reg     <= mem[ptr_reg];
         mem[ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (en) begin
         if (ptr_reg == AW'(DEPTH - 1)) begin
            ptr_reg <= '0;
         end else begin
            ptr_reg <= ptr_reg + AW'(1);
         end
      end
   end

   assign dout = dout_reg;

endmodule

// File: rtl/gradient_calc.sv
// Per-pixel Ix/Iy/It gradients over a 3x3 current-frame window with a matching
// previous-frame centre tap. Optional macro GRADIENT_STATS_EN adds motion_energy.
module gradient_calc
   import gradient_pkg::*;
#(
   parameter int PIXEL_WIDTH  = 8,
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int GRAD_WIDTH   = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [X_WIDTH-1:0]           pixel_x,
   input  logic [Y_WIDTH-1:0]           pixel_y,
   input  logic [PIXEL_WIDTH-1:0]       pixel_curr,
   input  logic [PIXEL_WIDTH-1:0]       pixel_prev,
   input  logic                         pixel_valid,
   input  logic                         frame_done,
   output logic signed [GRAD_WIDTH-1:0] grad_x,
   output logic signed [GRAD_WIDTH-1:0] grad_y,
   output logic signed [GRAD_WIDTH-1:0] grad_t,
   output logic [X_WIDTH-1:0]           out_x,
   output logic [Y_WIDTH-1:0]           out_y,
   output logic                         grad_valid,
   output logic                         grad_done
`ifdef GRADIENT_STATS_EN
   ,
   output logic [PIXEL_WIDTH+17:0]      motion_energy
`endif
);

   if (GRAD_WIDTH < PIXEL_WIDTH + 1) begin : g_bad_grad_width
      $error("GRAD_WIDTH must be at least PIXEL_WIDTH+1");
   end
   if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3) begin : g_bad_image_size
      $error("IMAGE_WIDTH and IMAGE_HEIGHT must be at least 3");
   end

   typedef struct packed {
      logic signed [GRAD_WIDTH-1:0] gx;
      logic signed [GRAD_WIDTH-1:0] gy;
      logic signed [GRAD_WIDTH-1:0] gt;
   } grad_s;

   state_e                 state_reg;
   logic [PIXEL_WIDTH-1:0] c_d1_reg;
   logic [PIXEL_WIDTH-1:0] l1_d1_reg;
   logic [PIXEL_WIDTH-1:0] l1_d2_reg;
   logic [PIXEL_WIDTH-1:0] l2_d1_reg;
   logic [PIXEL_WIDTH-1:0] p_d1_reg;
   logic [PIXEL_WIDTH-1:0] l1_out;
   logic [PIXEL_WIDTH-1:0] l2_out;
   logic [PIXEL_WIDTH-1:0] p_out;
   logic                   at_origin;
   logic                   accept;
   logic                   emit;
   logic                   done_next;
   grad_s                  grad_next;

   assign at_origin = (pixel_x == '0) && (pixel_y == '0);
   assign accept    = pixel_valid && ((state_reg == STREAM) || at_origin);
   assign emit      = accept && (pixel_x >= X_WIDTH'(2)) && (pixel_y >= Y_WIDTH'(2));
   assign done_next = frame_done && (state_reg == STREAM);

   // l1_out = curr(x,y-1), l2_out = curr(x,y-2), p_out = prev(x,y-1).
   line_buffer #(.WIDTH(PIXEL_WIDTH), .DEPTH(IMAGE_WIDTH - 1)) u_curr_line1 (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (pixel_curr),
      .dout (l1_out)
   );

   line_buffer #(.WIDTH(PIXEL_WIDTH), .DEPTH(IMAGE_WIDTH - 1)) u_curr_line2 (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (l1_out),
      .dout (l2_out)
   );

   line_buffer #(.WIDTH(PIXEL_WIDTH), .DEPTH(IMAGE_WIDTH - 1)) u_prev_line (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (pixel_prev),
      .dout (p_out)
   );

   // Centre is (x-1,y-1): right = l1_out, left = l1_d2, below = c_d1, above = l2_d1.
   always_comb begin
      grad_next    = '0;
      grad_next.gx = GRAD_WIDTH'(l1_out)   - GRAD_WIDTH'(l1_d2_reg);
      grad_next.gy = GRAD_WIDTH'(c_d1_reg) - GRAD_WIDTH'(l2_d1_reg);
      grad_next.gt = GRAD_WIDTH'(l1_d1_reg) - GRAD_WIDTH'(p_d1_reg);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         c_d1_reg   <= '0;
         l1_d1_reg  <= '0;
         l1_d2_reg  <= '0;
         l2_d1_reg  <= '0;
         p_d1_reg   <= '0;
         grad_x     <= '0;
         grad_y     <= '0;
         grad_t     <= '0;
         out_x      <= '0;
         out_y      <= '0;
         grad_valid <= 1'b0;
         grad_done  <= 1'b0;
      end else begin
         grad_valid <= emit;
         grad_done  <= done_next;
         if (accept) begin
            c_d1_reg  <= pixel_curr;
            l1_d1_reg <= l1_out;
            l1_d2_reg <= l1_d1_reg;
            l2_d1_reg <= l2_out;
            p_d1_reg  <= p_out;
         end
         if (emit) begin
            grad_x <= grad_next.gx;
            grad_y <= grad_next.gy;
            grad_t <= grad_next.gt;
            out_x  <= pixel_x - X_WIDTH'(1);
            out_y  <= pixel_y - Y_WIDTH'(1);
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg <= STREAM;
               end
            end
            STREAM: begin
               if (frame_done) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef GRADIENT_STATS_EN
   logic [GRAD_WIDTH-1:0]    gt_abs;
   logic [PIXEL_WIDTH+17:0]  acc_reg;
   logic [PIXEL_WIDTH+17:0]  acc_next;

   assign gt_abs = grad_next.gt[GRAD_WIDTH-1] ? -grad_next.gt : grad_next.gt;

   // acc_next already includes a pixel emitted alongside frame_done.
   always_comb begin
      acc_next = acc_reg;
      if (accept && at_origin) begin
         acc_next = '0;
      end else if (emit) begin
         acc_next = acc_reg + (PIXEL_WIDTH + 18)'(gt_abs);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg       <= '0;
         motion_energy <= '0;
      end else begin
         acc_reg <= acc_next;
         if (done_next) begin
            motion_energy <= acc_next;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gradient_calc.sv
// Scoreboard bench for gradient_calc on an 8x6 image: randomized frames and
// bubbles, mid-frame reset, restart without frame_done, idle-drop behaviour.
module tb_gradient_calc;

   localparam int PW = 8;
   localparam int IW = 8;
   localparam int IH = 6;
   localparam int GW = 9;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [9:0]           pixel_x = '0;
   logic [8:0]           pixel_y = '0;
   logic [PW-1:0]        pixel_curr = '0;
   logic [PW-1:0]        pixel_prev = '0;
   logic                 pixel_valid = 1'b0;
   logic                 frame_done = 1'b0;
   logic signed [GW-1:0] grad_x;
   logic signed [GW-1:0] grad_y;
   logic signed [GW-1:0] grad_t;
   logic [9:0]           out_x;
   logic [8:0]           out_y;
   logic                 grad_valid;
   logic                 grad_done;
`ifdef GRADIENT_STATS_EN
   logic [PW+17:0]       motion_energy;
`endif

   gradient_calc #(
      .PIXEL_WIDTH (PW),
      .IMAGE_WIDTH (IW),
      .IMAGE_HEIGHT(IH),
      .GRAD_WIDTH  (GW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .pixel_curr (pixel_curr),
      .pixel_prev (pixel_prev),
      .pixel_valid(pixel_valid),
      .frame_done (frame_done),
      .grad_x     (grad_x),
      .grad_y     (grad_y),
      .grad_t     (grad_t),
      .out_x      (out_x),
      .out_y      (out_y),
      .grad_valid (grad_valid),
      .grad_done  (grad_done)
`ifdef GRADIENT_STATS_EN
      ,
      .motion_energy(motion_energy)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int gx;
      int gy;
      int gt;
      int cx;
      int cy;
   } exp_s;

   exp_s exp_q[$];
   int   done_q[$];
   int   cur_img[IH][IW];
   int   prv_img[IH][IW];
   int   n_vec = 0;
   int   n_err = 0;
   logic tb_end = 1'b0;

   // Monitor: owns all comparisons and the counters.
   always @(negedge clk) begin
      exp_s e;
      int   ed;
      if (rst) begin
         n_vec++;
         if (grad_valid !== 1'b0 || grad_done !== 1'b0 || grad_x !== '0 || grad_y !== '0 ||
             grad_t !== '0 || out_x !== '0 || out_y !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got valid=%b done=%b gx=%0d gy=%0d gt=%0d x=%0d y=%0d want all 0",
                     grad_valid, grad_done, grad_x, grad_y, grad_t, out_x, out_y);
         end
`ifdef GRADIENT_STATS_EN
         n_vec++;
         if (motion_energy !== '0) begin
            n_err++;
            $display("FAIL reset_energy got %0d want 0", motion_energy);
         end
`endif
         n_vec++;
         if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_pending got %0d outstanding want 0", exp_q.size());
            exp_q.delete();
         end
      end else begin
         if (grad_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_grad got (%0d,%0d) gx=%0d gy=%0d gt=%0d want no output",
                        out_x, out_y, grad_x, grad_y, grad_t);
            end else begin
               e = exp_q.pop_front();
               if (int'(grad_x) != e.gx || int'(grad_y) != e.gy || int'(grad_t) != e.gt ||
                   int'(out_x) != e.cx || int'(out_y) != e.cy) begin
                  n_err++;
                  $display("FAIL grad got (%0d,%0d) gx=%0d gy=%0d gt=%0d want (%0d,%0d) gx=%0d gy=%0d gt=%0d",
                           out_x, out_y, grad_x, grad_y, grad_t, e.cx, e.cy, e.gx, e.gy, e.gt);
               end
            end
         end
         if (grad_done) begin
            n_vec++;
            if (done_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_done got grad_done=1 want 0");
            end else begin
               ed = done_q.pop_front();
               if (exp_q.size() != 0) begin
                  n_err++;
                  $display("FAIL done_early got %0d outputs outstanding want 0", exp_q.size());
               end
`ifdef GRADIENT_STATS_EN
               n_vec++;
               if (int'(motion_energy) != ed) begin
                  n_err++;
                  $display("FAIL motion_energy got %0d want %0d", motion_energy, ed);
               end
`else
               ed = ed + 0;
`endif
            end
         end
         if (tb_end) begin
            n_vec++;
            if (exp_q.size() != 0 || done_q.size() != 0) begin
               n_err++;
               $display("FAIL drain got %0d grads, %0d dones missing want 0,0", exp_q.size(), done_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic fill_img(input int mode);
      for (int y = 0; y < IH; y++) begin
         for (int x = 0; x < IW; x++) begin
            case (mode)
               0: begin cur_img[y][x] = 10*x + 20*y; prv_img[y][x] = (cur_img[y][x] - 3) & 255; end
               1: begin cur_img[y][x] = 255 - 10*x;  prv_img[y][x] = cur_img[y][x]; end
               2: begin cur_img[y][x] = (x >= 4) ? 255 : 0; prv_img[y][x] = 0; end
               default: begin
                  cur_img[y][x] = int'($urandom_range(255));
                  prv_img[y][x] = int'($urandom_range(255));
               end
            endcase
         end
      end
   endtask

   task automatic step(input logic v, input int x, input int y, input int c, input int p, input logic fd);
      pixel_valid = v;
      pixel_x     = 10'(x);
      pixel_y     = 9'(y);
      pixel_curr  = PW'(c);
      pixel_prev  = PW'(p);
      frame_done  = fd;
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      frame_done  = 1'b0;
   endtask

   // Drives one frame; stop_row >= 0 abandons it at column 3 of that row.
   task automatic drive_frame(input int mode, input int pct, input int stop_row);
      int   energy;
      int   cx;
      int   cy;
      int   gt;
      logic fd_with_last;
      exp_s e;
      energy = 0;
      fill_img(mode);
      fd_with_last = 1'($urandom_range(1));
      for (int y = 0; y < IH; y++) begin
         for (int x = 0; x < IW; x++) begin
            if (y == stop_row && x == 3) return;
            while (int'($urandom_range(99)) < pct) begin
               step(1'b0, int'($urandom_range(IW-1)), int'($urandom_range(IH-1)), 0, 0, 1'b0);
            end
            if (x >= 2 && y >= 2) begin
               cx   = x - 1;
               cy   = y - 1;
               gt   = cur_img[cy][cx] - prv_img[cy][cx];
               e.gx = cur_img[cy][cx+1] - cur_img[cy][cx-1];
               e.gy = cur_img[cy+1][cx] - cur_img[cy-1][cx];
               e.gt = gt;
               e.cx = cx;
               e.cy = cy;
               exp_q.push_back(e);
               energy += (gt < 0) ? -gt : gt;
            end
            if (x == IW-1 && y == IH-1 && fd_with_last) begin
               done_q.push_back(energy);
               step(1'b1, x, y, cur_img[y][x], prv_img[y][x], 1'b1);
            end else begin
               step(1'b1, x, y, cur_img[y][x], prv_img[y][x], 1'b0);
            end
         end
      end
      if (!fd_with_last) begin
         done_q.push_back(energy);
         step(1'b0, 0, 0, 0, 0, 1'b1);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      // Idle: non-origin valid pixels and frame_done must all be ignored.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, int'($urandom_range(1, IW-1)), int'($urandom_range(IH-1)), 77, 11, 1'(i == 3));
      end
      drive_frame(0, 0, -1);
      drive_frame(1, 0, -1);
      drive_frame(2, 0, -1);
      drive_frame(0, 30, -1);
      drive_frame(3, 20, 3);
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, int'($urandom_range(2, IW-1)), int'($urandom_range(2, IH-1)), 99, 1, 1'b0);
      end
      drive_frame(0, 0, -1);
      drive_frame(3, 25, 4);
      drive_frame(3, 25, -1);
      drive_frame(0, 10, -1);
      drive_frame(0, 0, -1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 0, 0, 0, 0, 1'b0);
      end
      tb_end = 1'b1;
   end

endmodule
